// File: rtl/ifq_if.sv
// ifq_if: fetch/decode handshake bundle around the instruction fetch queue.
interface ifq_if #(parameter int AW = 2);
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        pc_write_en;
    logic        im_next_en;
    logic        flush;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_valid;
    logic        out_ready;
    logic [AW:0] count;
    modport master (
        output in_inst, in_pc, flush, out_ready,
        input  pc_write_en, im_next_en, out_inst, out_pc, out_valid, count
    );
    modport slave (
        input  in_inst, in_pc, flush, out_ready,
        output pc_write_en, im_next_en, out_inst, out_pc, out_valid, count
    );
endinterface

// File: rtl/ifq.sv
// ifq: instruction fetch queue between fetch unit and decode, flushable on redirect.
module ifq #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic  clk,
    input logic  reset,
    ifq_if.slave q
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          full, empty, enq, deq;
    // Fetch advances only on registered room, so decode's ready never reaches pc_write_en.
    always_comb begin
        full          = count == FULL_CNT;
        empty         = count == '0;
        q.pc_write_en = (!full || q.flush) && !reset;
        q.im_next_en  = q.pc_write_en;
        enq           = q.pc_write_en && !q.flush;
        deq           = !empty && q.out_ready && !q.flush;
        q.out_valid   = !empty;
        q.count       = count;
        {q.out_pc, q.out_inst} = empty ? 64'd0 : mem[rd_ptr];
    end
    always_ff @(posedge clk)
        if (enq) mem[wr_ptr] <= {q.in_pc, q.in_inst};
    always_ff @(posedge clk) begin
        if (reset || q.flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + AW'(1);
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(enq) - (AW+1)'(deq);
        end
    end
endmodule
